// File: rtl/dmem_pkg.sv
// dmem_pkg: shared word type, widths and index helper for the RV32 data memory.
package dmem_pkg;
    localparam int DATA_W      = 32;
    localparam int BYTE_OFFS_W = 2;
    typedef logic [DATA_W-1:0] word_t;
    function automatic int idx_w(input int depth);
        return $clog2(depth);
    endfunction
endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: single-port word array with write-first registered read.
// Contents survive reset; only the read register is cleared.
module dmem_ram
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    localparam int IDX_W = idx_w(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] idx,
    input  logic             we,
    input  word_t            wdata,
    output word_t            rdata
);
    word_t r_mem [DEPTH_WORDS] = '{default: '0};
    // An X on we takes the else path, so it behaves as a read with no store.
    always_ff @(posedge clk) begin
        if (rst_n && we) r_mem[idx] <= wdata;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata <= '0;
        else if (we) rdata <= wdata;
        else rdata <= r_mem[idx];
    end
    always @(posedge clk) begin
        assert (!rst_n || !$isunknown(we));
    end
endmodule

// File: rtl/dmem_fetch.sv
// dmem_fetch: RV32 data memory front end: address decode, reset gating, 1-cycle loads.
// Define DMEM_ADDR_CHECK_EN to add o_addr_err and block misaligned/out-of-range accesses.
module dmem_fetch
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_addr,
    input  logic        i_we,
    input  word_t       i_data_to_mem,
`ifdef DMEM_ADDR_CHECK_EN
    output logic        o_addr_err,
`endif
    output word_t       o_data_from_mem
);
    localparam int IDX_W  = idx_w(DEPTH_WORDS);
    localparam int HI_LSB = IDX_W + BYTE_OFFS_W;
    logic [IDX_W-1:0] w_idx;
    logic             w_we;
    word_t            w_rdata;
    assign w_idx = i_addr[HI_LSB-1:BYTE_OFFS_W];
`ifdef DMEM_ADDR_CHECK_EN
    logic w_err;
    logic r_err;
    assign w_err = (|i_addr[31:HI_LSB]) | (|i_addr[BYTE_OFFS_W-1:0]);
    assign w_we  = i_we & ~w_err;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_err <= 1'b0;
        else r_err <= w_err;
    end
    assign o_addr_err      = r_err;
    assign o_data_from_mem = r_err ? '0 : w_rdata;
`else
    logic w_unused;
    assign w_unused        = ^{i_addr[31:HI_LSB], i_addr[BYTE_OFFS_W-1:0]};
    assign w_we            = i_we;
    assign o_data_from_mem = w_rdata;
`endif
    dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .idx   (w_idx),
        .we    (w_we),
        .wdata (i_data_to_mem),
        .rdata (w_rdata)
    );
endmodule

// File: tb/tb_dmem_fetch.sv
// tb_dmem_fetch: directed and random checks of dmem_fetch against a word-array reference model.
module tb_dmem_fetch;
    localparam int DEPTH = 1024;
    logic        i_clk;
    logic        i_rst_n;
    logic [31:0] i_addr;
    logic        i_we;
    logic [31:0] i_data_to_mem;
    logic [31:0] o_data_from_mem;
`ifdef DMEM_ADDR_CHECK_EN
    logic        o_addr_err;
`endif
    int checks = 0;
    int errors = 0;
    logic [31:0] model_mem [DEPTH];
    logic [31:0] exp_data;
    logic        exp_err;

    dmem_fetch #(.DEPTH_WORDS(DEPTH)) dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_addr          (i_addr),
        .i_we            (i_we),
        .i_data_to_mem   (i_data_to_mem),
`ifdef DMEM_ADDR_CHECK_EN
        .o_addr_err      (o_addr_err),
`endif
        .o_data_from_mem (o_data_from_mem)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Reference: byte address -> word slot modulo DEPTH words; faulting accesses only in check builds.
    task automatic step(input logic [31:0] a, input logic we, input logic [31:0] d);
        int unsigned idx;
        logic bad;
        i_addr = a;
        i_we = we;
        i_data_to_mem = d;
        @(posedge i_clk);
        bad = 1'b0;
`ifdef DMEM_ADDR_CHECK_EN
        bad = (a >= 32'(DEPTH * 4)) || (a % 4 != 0);
`endif
        idx = (a / 4) % DEPTH;
        if (bad) exp_data = '0;
        else if (we) begin
            model_mem[idx] = d;
            exp_data = d;
        end else exp_data = model_mem[idx];
        exp_err = bad;
        #1;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b1;
        i_addr = '0;
        i_we = 1'b1;
        i_data_to_mem = 32'hFFFF_FFFF;
        #1 i_rst_n = 1'b0;
        #1;
        checks++;
        if (o_data_from_mem !== 32'h0) begin
            errors++;
            $display("FAIL rst_async got %h want %h", o_data_from_mem, 32'h0);
        end
        repeat (2) begin
            @(posedge i_clk);
            #1;
            checks++;
            if (o_data_from_mem !== 32'h0) begin
                errors++;
                $display("FAIL rst_hold got %h want %h", o_data_from_mem, 32'h0);
            end
        end
        i_rst_n = 1'b1;
        step(32'h0, 1'b0, 32'h0);
        checks++;
        if (o_data_from_mem !== 32'h0 || exp_data !== 32'h0) begin
            errors++;
            $display("FAIL rst_read0 got %h want %h", o_data_from_mem, 32'h0);
        end
    endtask

    task automatic test_write_read();
        step(32'h10, 1'b1, 32'hDEAD_BEEF);
        step(32'h10, 1'b0, 32'h0);
        checks++;
        if (o_data_from_mem !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL wr_rd got %h want %h", o_data_from_mem, 32'hDEAD_BEEF);
        end
        step(32'h13, 1'b0, 32'h0);
        checks++;
        if (o_data_from_mem !== exp_data) begin
            errors++;
            $display("FAIL rd_lowbits got %h want %h", o_data_from_mem, exp_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [3] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
        for (int i = 0; i < 3; i++) step(32'(i * 4), 1'b1, vals[i]);
        for (int i = 2; i >= 0; i--) begin
            step(32'(i * 4), 1'b0, 32'h0);
            checks++;
            if (o_data_from_mem !== vals[i]) begin
                errors++;
                $display("FAIL b2b[%0d] got %h want %h", i, o_data_from_mem, vals[i]);
            end
        end
    endtask

    task automatic test_read_during_write();
        step(32'h10, 1'b1, 32'hCAFE_F00D);
        checks++;
        if (o_data_from_mem !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL rdw got %h want %h", o_data_from_mem, 32'hCAFE_F00D);
        end
    endtask

    task automatic test_alias();
        step(32'h1000, 1'b1, 32'hA5A5_A5A5);
`ifdef DMEM_ADDR_CHECK_EN
        checks++;
        if (o_addr_err !== 1'b1) begin
            errors++;
            $display("FAIL alias_err got %b want %b", o_addr_err, 1'b1);
        end
`endif
        step(32'h0, 1'b0, 32'h0);
        checks++;
`ifdef DMEM_ADDR_CHECK_EN
        if (o_data_from_mem !== 32'h1111_1111) begin
            errors++;
            $display("FAIL alias_rd0 got %h want %h", o_data_from_mem, 32'h1111_1111);
        end
`else
        if (o_data_from_mem !== 32'hA5A5_A5A5) begin
            errors++;
            $display("FAIL alias_rd0 got %h want %h", o_data_from_mem, 32'hA5A5_A5A5);
        end
`endif
        step(32'h1000, 1'b0, 32'h0);
        checks++;
        if (o_data_from_mem !== exp_data) begin
            errors++;
            $display("FAIL alias_rd1000 got %h want %h", o_data_from_mem, exp_data);
        end
    endtask

    task automatic test_reset_mid();
        step(32'h20, 1'b1, 32'h1234_5678);
        i_we = 1'b0;
        i_rst_n = 1'b0;
        #1;
        checks++;
        if (o_data_from_mem !== 32'h0) begin
            errors++;
            $display("FAIL mid_rst_async got %h want %h", o_data_from_mem, 32'h0);
        end
        #4 i_rst_n = 1'b1;
        #1;
        checks++;
        if (o_data_from_mem !== 32'h0) begin
            errors++;
            $display("FAIL mid_rst_hold got %h want %h", o_data_from_mem, 32'h0);
        end
        i_rst_n = 1'b0;
        i_addr = 32'h20;
        i_we = 1'b1;
        i_data_to_mem = 32'hBAD0_BAD0;
        @(posedge i_clk);
        #1;
        checks++;
        if (o_data_from_mem !== 32'h0) begin
            errors++;
            $display("FAIL mid_rst_edge got %h want %h", o_data_from_mem, 32'h0);
        end
`ifdef DMEM_ADDR_CHECK_EN
        checks++;
        if (o_addr_err !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_err got %b want %b", o_addr_err, 1'b0);
        end
`endif
        i_rst_n = 1'b1;
        step(32'h20, 1'b0, 32'h0);
        checks++;
        if (o_data_from_mem !== 32'h1234_5678) begin
            errors++;
            $display("FAIL mid_rst_retain got %h want %h", o_data_from_mem, 32'h1234_5678);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 3))
                0, 1: a = 32'($urandom_range(0, DEPTH - 1) * 4);
                2: a = 32'($urandom_range(0, DEPTH * 4 - 1));
                default: a = $urandom;
            endcase
            step(a, 1'($urandom_range(0, 1)), $urandom);
            checks++;
            if (o_data_from_mem !== exp_data) begin
                errors++;
                $display("FAIL rand[%0d] addr %h got %h want %h", n, a, o_data_from_mem, exp_data);
            end
`ifdef DMEM_ADDR_CHECK_EN
            checks++;
            if (o_addr_err !== exp_err) begin
                errors++;
                $display("FAIL rand_err[%0d] addr %h got %b want %b", n, a, o_addr_err, exp_err);
            end
`endif
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        exp_data = '0;
        exp_err = 1'b0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_read_during_write();
        test_alias();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
